// File: rtl/line_tracker_pkg.sv
// Shared direction codes, tracker state encoding and the accepted-pattern map.
package line_tracker_pkg;

  // Action codes in dirControl[3:2]
  localparam logic [1:0] DC_PROCEED    = 2'b00;
  localparam logic [1:0] DC_TURN_LEFT  = 2'b01;
  localparam logic [1:0] DC_TURN_RIGHT = 2'b10;
  // DC_STOP is both the stop action and the stop severity (same encoding).
  localparam logic [1:0] DC_STOP       = 2'b11;
  // Severity codes in dirControl[1:0]
  localparam logic [1:0] DC_NONE       = 2'b00;
  localparam logic [1:0] DC_VEER       = 2'b01;
  localparam logic [1:0] DC_HARD       = 2'b10;

  typedef enum logic [1:0] {
    TRACK    = 2'd0,
    JUNCTION = 2'd1,
    LOST     = 2'd2
  } trackState_t;

  typedef struct packed {
    logic       hit;
    logic [3:0] code;
  } mapResult_t;

  function automatic mapResult_t mapPattern(input logic [4:0] pattern);
    mapResult_t r;
    r.hit  = 1'b1;
    r.code = {DC_STOP, DC_STOP};
    case (pattern)
      5'b00100:          r.code = {DC_PROCEED,    DC_NONE};
      5'b01100, 5'b01000: r.code = {DC_TURN_LEFT,  DC_VEER};
      5'b00110, 5'b00010: r.code = {DC_TURN_RIGHT, DC_VEER};
      5'b10000, 5'b11000: r.code = {DC_TURN_LEFT,  DC_HARD};
      5'b00001, 5'b00011: r.code = {DC_TURN_RIGHT, DC_HARD};
      5'b11100, 5'b11110: r.code = {DC_TURN_LEFT,  DC_STOP};
      5'b00111, 5'b01111: r.code = {DC_TURN_RIGHT, DC_STOP};
      5'b11111:          r.code = {DC_STOP,       DC_STOP};
      default:           r.hit  = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sensor_filter.sv
// Sensor synchronizer, sample-strobe divider and STABLE_N debounce filter.
// accepted_valid is combinational during the strobe cycle; a held pattern re-accepts every strobe.
module sensor_filter
  import line_tracker_pkg::*;
#(
  parameter int SAMPLE_DIV = 50_000,
  parameter int STABLE_N   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] sensor,
  output logic       accepted_valid,
  output logic [4:0] accepted_pattern
);

  localparam int DIV_W = $clog2(SAMPLE_DIV);

  logic [4:0]       syncA;
  logic [4:0]       syncB;
  logic [4:0]       lastSample;
  logic [DIV_W-1:0] divCnt;
  logic [3:0]       matchCnt;
  logic             strobe;
  logic             same;
  logic [3:0]       nextMatch;

  assign strobe    = (divCnt == DIV_W'(SAMPLE_DIV - 1));
  // matchCnt == 0 means no history yet, so the first sample never counts as a repeat.
  assign same      = (matchCnt != 4'd0) && (syncB == lastSample);
  assign nextMatch = !same ? 4'd1 : ((matchCnt == 4'd15) ? 4'd15 : matchCnt + 4'd1);

  assign accepted_valid   = strobe && (nextMatch >= 4'(STABLE_N));
  assign accepted_pattern = syncB;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syncA      <= '0;
      syncB      <= '0;
      lastSample <= '0;
      divCnt     <= '0;
      matchCnt   <= '0;
    end else begin
      syncA <= sensor;
      syncB <= syncA;
      if (strobe) begin
        divCnt     <= '0;
        lastSample <= syncB;
        matchCnt   <= nextMatch;
      end else begin
        divCnt <= divCnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/line_tracker.sv
// Line-following tracker: maps debounced sensor patterns to direction codes and runs TRACK/JUNCTION/LOST.
// Define LOST_SEARCH_EN to steer toward the last seen side while LOST; otherwise LOST outputs the stop code.
module line_tracker
  import line_tracker_pkg::*;
#(
  parameter int SAMPLE_DIV = 50_000,
  parameter int STABLE_N   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] sensor,
  output logic [3:0] dirControl,
  output logic       junction,
  output logic [7:0] jncCount,
  output logic       lost
);

`ifdef LOST_SEARCH_EN
  localparam bit LOST_SEARCH = 1'b1;
`else
  localparam bit LOST_SEARCH = 1'b0;
`endif

  logic        acceptedValid;
  logic [4:0]  acceptedPattern;
  trackState_t state;
  logic        lastSide;  // 0 = left, 1 = right
  mapResult_t  mapped;
  logic [3:0]  lostCode;

  sensor_filter #(
    .SAMPLE_DIV(SAMPLE_DIV),
    .STABLE_N  (STABLE_N)
  ) u_filter (
    .clk             (clk),
    .rst_n           (rst_n),
    .sensor          (sensor),
    .accepted_valid  (acceptedValid),
    .accepted_pattern(acceptedPattern)
  );

  assign mapped   = mapPattern(acceptedPattern);
  assign lostCode = !LOST_SEARCH ? {DC_STOP, DC_STOP} :
                    (lastSide ? {DC_TURN_RIGHT, DC_HARD} : {DC_TURN_LEFT, DC_HARD});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= TRACK;
      dirControl <= {DC_STOP, DC_STOP};
      junction   <= 1'b0;
      jncCount   <= '0;
      lost       <= 1'b0;
      lastSide   <= 1'b0;
    end else begin
      junction <= 1'b0;
      if (acceptedValid) begin
        if (acceptedPattern == 5'b00000) begin
          state      <= LOST;
          lost       <= 1'b1;
          dirControl <= lostCode;
        end else if (acceptedPattern == 5'b11111) begin
          // Only a fresh entry counts; holding 11111 re-accepts every strobe.
          if (state != JUNCTION) begin
            junction <= 1'b1;
            jncCount <= jncCount + 8'd1;
          end
          state      <= JUNCTION;
          lost       <= 1'b0;
          dirControl <= mapped.code;
        end else begin
          state <= TRACK;
          lost  <= 1'b0;
          if (mapped.hit) begin
            dirControl <= mapped.code;
            if (mapped.code[3:2] == DC_TURN_LEFT)
              lastSide <= 1'b0;
            else if (mapped.code[3:2] == DC_TURN_RIGHT)
              lastSide <= 1'b1;
          end
        end
      end
    end
  end

endmodule
